// File: rtl/pe_stream_driver.sv
// Feeds (north, west) element pairs to a single processing element one at a time,
// then drains the PE accumulator into result_o. Every PE wait is guarded by a watchdog.
module pe_stream_driver #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  src_valid_i,
  input  logic [DATA_WIDTH-1:0] src_north_i,
  input  logic [DATA_WIDTH-1:0] src_west_i,
  output logic                  src_ready_o,
  output logic [DATA_WIDTH-1:0] pe_north_o,
  output logic [DATA_WIDTH-1:0] pe_west_o,
  output logic                  pe_inputs_valid_o,
  output logic                  pe_last_element_o,
  output logic                  pe_select_accumulator_o,
  input  logic                  pe_passthrough_valid_i,
  input  logic                  pe_accumulator_valid_i,
  input  logic [DATA_WIDTH-1:0] pe_east_i,
  input  logic                  pe_done_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  result_valid_o,
  output logic                  busy_o,
  output logic                  error_o
);

  // The watchdog only has to count 0..TIMEOUT-1; the last value fires it.
  localparam int WD_WIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_PT,
    WAIT_DONE,
    DRAIN,
    RESULT
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [LEN_WIDTH-1:0] count;
  logic [WD_WIDTH-1:0]  wdog;
  logic                 accept_start;
  logic                 accept_elem;
  logic                 capture_result;
  logic                 waiting;
  logic                 wd_expired;
  logic                 timeout_hit;

  assign accept_start   = (state == IDLE) && start_i && (len_i != '0);
  assign accept_elem    = (state == FETCH) && src_valid_i;
  assign capture_result = (state == DRAIN) && pe_accumulator_valid_i;
  assign waiting        = (state == WAIT_PT) || (state == WAIT_DONE) || (state == DRAIN);
  assign wd_expired     = waiting && (wdog == WD_LAST);

  assign src_ready_o             = (state == FETCH);
  assign pe_inputs_valid_o       = (state == ISSUE);
  assign pe_last_element_o       = (state == ISSUE) && (count == '0);
  assign pe_select_accumulator_o = (state == DRAIN);
  assign result_valid_o          = (state == RESULT);
  assign busy_o                  = (state != IDLE);

  // A genuine PE response in the same cycle as expiry wins over the timeout.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (accept_start) state_next = FETCH;
      end
      FETCH: begin
        if (src_valid_i) state_next = ISSUE;
      end
      ISSUE: begin
        state_next = WAIT_PT;
      end
      WAIT_PT: begin
        if (pe_passthrough_valid_i) begin
          state_next = (count != '0) ? FETCH : WAIT_DONE;
        end else if (wd_expired) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (pe_done_i) begin
          state_next = DRAIN;
        end else if (wd_expired) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      DRAIN: begin
        if (pe_accumulator_valid_i) begin
          state_next = RESULT;
        end else if (wd_expired) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      RESULT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      count   <= '0;
      wdog    <= '0;
      error_o <= 1'b0;
    end else begin
      state <= state_next;
      // Restart the watchdog on every state entry so each wait gets a full budget.
      if (!waiting || (state_next != state)) begin
        wdog <= '0;
      end else begin
        wdog <= wdog + WD_WIDTH'(1);
      end
      if (accept_start) begin
        count   <= len_i;
        error_o <= 1'b0;
      end else if (accept_elem) begin
        count <= count - LEN_WIDTH'(1);
      end
      if (timeout_hit) error_o <= 1'b1;
    end
  end

  // Element registers only change in FETCH, so they stay put through ISSUE and WAIT_PT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pe_north_o <= '0;
      pe_west_o  <= '0;
      result_o   <= '0;
    end else begin
      if (accept_elem) begin
        pe_north_o <= src_north_i;
        pe_west_o  <= src_west_i;
      end
      if (capture_result) result_o <= pe_east_i;
    end
  end

endmodule

// File: tb/tb_pe_stream_driver.sv
// Directed bench for pe_stream_driver: a behavioural PE model, scoreboard queues filled
// by the stimulus, and independent monitors that pop and compare on DUT strobes.
module tb_pe_stream_driver;

  typedef struct packed {
    logic        last;
    logic [31:0] north;
    logic [31:0] west;
  } elem_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        src_valid;
  logic [31:0] src_north;
  logic [31:0] src_west;
  logic        src_ready_o;
  logic [31:0] pe_north_o;
  logic [31:0] pe_west_o;
  logic        pe_inputs_valid_o;
  logic        pe_last_element_o;
  logic        pe_select_accumulator_o;
  logic        pe_pt_valid;
  logic        pe_acc_valid;
  logic [31:0] pe_east;
  logic        pe_done;
  logic [31:0] result_o;
  logic        result_valid_o;
  logic        busy_o;
  logic        error_o;

  int          checks = 0;
  int          errors = 0;
  elem_t       exp_elem[$];
  logic [31:0] exp_result[$];
  logic [31:0] vec_n[8];
  logic [31:0] vec_w[8];
  bit          pt_enable;
  bit          sticky_mode;

  pe_stream_driver #(
    .DATA_WIDTH(32),
    .LEN_WIDTH (8),
    .TIMEOUT   (8)
  ) dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .start_i                (start),
    .len_i                  (len),
    .src_valid_i            (src_valid),
    .src_north_i            (src_north),
    .src_west_i             (src_west),
    .src_ready_o            (src_ready_o),
    .pe_north_o             (pe_north_o),
    .pe_west_o              (pe_west_o),
    .pe_inputs_valid_o      (pe_inputs_valid_o),
    .pe_last_element_o      (pe_last_element_o),
    .pe_select_accumulator_o(pe_select_accumulator_o),
    .pe_passthrough_valid_i (pe_pt_valid),
    .pe_accumulator_valid_i (pe_acc_valid),
    .pe_east_i              (pe_east),
    .pe_done_i              (pe_done),
    .result_o               (result_o),
    .result_valid_o         (result_valid_o),
    .busy_o                 (busy_o),
    .error_o                (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int c = 0; c < 300 && !idle; c++) begin
      @(negedge clk);
      if (!busy_o) idle = 1'b1;
    end
    if (!idle) checkOutput("idle_timeout", 64'd0, 64'd1);
  endtask

  // Queues the expected issues/result, pulses start, then hands each element over.
  task automatic applyStimulus(input int n, input logic [31:0] expected, input bit push_result,
                               input bit toggle, input bit spurious);
    elem_t e;
    bit    accepted;
    for (int i = 0; i < n; i++) begin
      e.last  = (i == n - 1);
      e.north = vec_n[i];
      e.west  = vec_w[i];
      exp_elem.push_back(e);
    end
    if (push_result) exp_result.push_back(expected);
    start = 1'b1;
    len   = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = 8'd0;
    for (int i = 0; i < n; i++) begin
      if (toggle) begin
        src_valid = 1'b0;
        @(posedge clk); #1;
      end
      src_valid = 1'b1;
      src_north = vec_n[i];
      src_west  = vec_w[i];
      accepted  = 1'b0;
      for (int c = 0; c < 200 && !accepted; c++) begin
        @(negedge clk);
        if (src_ready_o) accepted = 1'b1;
        @(posedge clk); #1;
      end
      if (!accepted) checkOutput("fetch_timeout", 64'd0, 64'd1);
      src_valid = 1'b0;
      if (spurious && i == 0) begin
        start = 1'b1;
        len   = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        len   = 8'd0;
      end
    end
    src_valid = 1'b0;
  endtask

  // Behavioural PE: passthrough 4 cycles after valid, done one cycle after the last
  // passthrough, accumulator returned 2 cycles after select is first seen.
  initial begin : pe_model
    logic [31:0] acc;
    int          pt_timer;
    int          acc_timer;
    bit          pt_last;
    bit          done_pending;
    bit          acc_armed;
    bit          job_open;
    acc = 0; pt_timer = 0; acc_timer = 0; pt_last = 0;
    done_pending = 0; acc_armed = 0; job_open = 0;
    pe_pt_valid = 1'b0; pe_acc_valid = 1'b0; pe_east = '0; pe_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      pe_pt_valid  = 1'b0;
      pe_acc_valid = 1'b0;
      if (rst) begin
        acc = 0; pt_timer = 0; acc_timer = 0; done_pending = 0;
        acc_armed = 0; job_open = 0; pe_done = 1'b0;
      end else begin
        if (!busy_o) job_open = 0;
        if (done_pending) begin
          pe_done      = 1'b1;
          done_pending = 0;
        end
        if (pe_inputs_valid_o) begin
          if (!job_open) begin
            acc      = 0;
            job_open = 1;
            if (!sticky_mode) pe_done = 1'b0;
          end
          acc      = acc + pe_north_o * pe_west_o;
          pt_timer = 4;
          pt_last  = pe_last_element_o;
        end else if (pt_timer != 0) begin
          pt_timer--;
          if (pt_timer == 0 && pt_enable) begin
            pe_pt_valid = 1'b1;
            if (pt_last) done_pending = 1;
          end
        end
        if (pe_select_accumulator_o) begin
          if (!acc_armed) begin
            acc_armed = 1;
            acc_timer = 2;
          end else if (acc_timer != 0) begin
            acc_timer--;
            if (acc_timer == 0) begin
              pe_acc_valid = 1'b1;
              pe_east      = acc;
            end
          end
        end else begin
          acc_armed = 0;
        end
      end
    end
  end

  initial begin : elem_monitor
    elem_t       e;
    bit          have_held;
    logic [31:0] hn;
    logic [31:0] hw;
    have_held = 0; hn = '0; hw = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_held = 0;
      end else begin
        if (pe_inputs_valid_o) begin
          if (exp_elem.size() == 0) begin
            checkOutput("unexpected_issue", 64'd1, 64'd0);
          end else begin
            e = exp_elem.pop_front();
            checkOutput("issue_north", 64'(pe_north_o), 64'(e.north));
            checkOutput("issue_west", 64'(pe_west_o), 64'(e.west));
            checkOutput("issue_last", 64'(pe_last_element_o), 64'(e.last));
            hn = e.north;
            hw = e.west;
            have_held = 1;
          end
        end
        if (pe_pt_valid && have_held) begin
          checkOutput("hold_north", 64'(pe_north_o), 64'(hn));
          checkOutput("hold_west", 64'(pe_west_o), 64'(hw));
          have_held = 0;
        end
      end
    end
  end

  initial begin : result_monitor
    logic [31:0] r;
    forever begin
      @(negedge clk);
      if (!rst && result_valid_o) begin
        if (exp_result.size() == 0) begin
          checkOutput("unexpected_result", 64'd1, 64'd0);
        end else begin
          r = exp_result.pop_front();
          checkOutput("result_value", 64'(result_o), 64'(r));
        end
      end
    end
  end

  initial begin : strobe_monitor
    forever begin
      @(negedge clk);
      if (!rst && (pe_inputs_valid_o || pe_last_element_o || pe_select_accumulator_o))
        checkOutput("strobe_exclusive",
                    64'((pe_select_accumulator_o && (pe_inputs_valid_o || pe_last_element_o)) ||
                        (pe_last_element_o && !pe_inputs_valid_o)), 64'd0);
    end
  end

  initial begin : global_bound
    #1000000;
    $display("[TB] FAIL global_timeout: actual=1 required=0");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    bit found;
    rst = 1'b1; start = 1'b0; len = '0; src_valid = 1'b0; src_north = '0; src_west = '0;
    pt_enable = 1; sticky_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", 64'(busy_o), 64'd0);
    checkOutput("rst_ready", 64'(src_ready_o), 64'd0);
    checkOutput("rst_valid", 64'(pe_inputs_valid_o), 64'd0);
    checkOutput("rst_select", 64'(pe_select_accumulator_o), 64'd0);
    checkOutput("rst_error", 64'(error_o), 64'd0);
    checkOutput("rst_north", 64'(pe_north_o), 64'd0);
    checkOutput("rst_result", 64'(result_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] single element job 3*4");
    vec_n[0] = 3; vec_w[0] = 4;
    applyStimulus(1, 32'd12, 1'b1, 1'b0, 1'b0);
    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("result_hold", 64'(result_o), 64'd12);
    checkOutput("busy_after", 64'(busy_o), 64'd0);
    checkOutput("error_after", 64'(error_o), 64'd0);

    $display("[TB] three element job with gapped source");
    vec_n[0] = 1; vec_w[0] = 2;
    vec_n[1] = 3; vec_w[1] = 4;
    vec_n[2] = 5; vec_w[2] = 6;
    applyStimulus(3, 32'd44, 1'b1, 1'b1, 1'b0);
    waitIdle();

    $display("[TB] start pulsed while busy, done left high from the previous job");
    sticky_mode = 1;
    vec_n[0] = 2; vec_w[0] = 3;
    vec_n[1] = 4; vec_w[1] = 5;
    applyStimulus(2, 32'd26, 1'b1, 1'b0, 1'b1);
    waitIdle();
    sticky_mode = 0;
    checkOutput("spurious_result_hold", 64'(result_o), 64'd26);

    $display("[TB] zero-length start");
    @(posedge clk); #1;
    start = 1'b1; len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("len0_busy", 64'(busy_o), 64'd0);
      checkOutput("len0_valid", 64'(pe_inputs_valid_o), 64'd0);
    end

    $display("[TB] passthrough never arrives");
    pt_enable = 0;
    vec_n[0] = 9; vec_w[0] = 9;
    applyStimulus(1, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("to_issue", 64'(pe_inputs_valid_o), 64'd1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) begin
        checkOutput("to_early_error", 64'(error_o), 64'd0);
        checkOutput("to_early_busy", 64'(busy_o), 64'd1);
      end
      if (k == 9) begin
        checkOutput("to_error", 64'(error_o), 64'd1);
        checkOutput("to_busy", 64'(busy_o), 64'd0);
      end
    end
    pt_enable = 1;
    repeat (4) @(negedge clk);
    checkOutput("to_error_sticky", 64'(error_o), 64'd1);
    start = 1'b1; len = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("to_error_len0", 64'(error_o), 64'd1);
    vec_n[0] = 7; vec_w[0] = 6;
    applyStimulus(1, 32'd42, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("error_cleared", 64'(error_o), 64'd0);
    waitIdle();

    $display("[TB] reset during accumulator drain");
    vec_n[0] = 8; vec_w[0] = 8;
    applyStimulus(1, 32'd0, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (pe_select_accumulator_o) found = 1'b1;
    end
    checkOutput("drain_reached", 64'(found), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("drst_select", 64'(pe_select_accumulator_o), 64'd0);
    checkOutput("drst_busy", 64'(busy_o), 64'd0);
    checkOutput("drst_result_valid", 64'(result_valid_o), 64'd0);
    checkOutput("drst_result", 64'(result_o), 64'd0);
    checkOutput("drst_north", 64'(pe_north_o), 64'd0);
    checkOutput("drst_west", 64'(pe_west_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("post_reset_busy", 64'(busy_o), 64'd0);

    checkOutput("elem_queue_empty", 64'(exp_elem.size()), 64'd0);
    checkOutput("result_queue_empty", 64'(exp_result.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
